// File: rtl/router_fifo_ch.sv
// router_fifo_ch
// ---------------------------------------------------------------------------
// One output-channel FIFO of the 1x3 router. Bytes arrive on this channel's
// bit of the synchroniser's one-hot write enable and are stored together with
// a header flag (lfd_state). On the read side a packet-length counter is
// loaded from each header as it is popped. The registered output byte is
// forced to zero only when no packet is being read out, so the downstream
// port sees a quiet bus between packets.
//
// Build option:
//   ROUTER_FIFO_TIMEOUT_EN - when defined, an internal stall counter flushes
//   the channel after 30 consecutive cycles with data held and no read
//   request. The external soft_reset still works alongside it.
//
// Ports:
//   clock       in   1      rising-edge clock for all state
//   reset       in   1      synchronous active-high reset; clears everything,
//                           including every memory entry
//   soft_reset  in   1      synchronous channel flush (pointers, packet
//                           counter, data_out); memory is left stale
//   write_enb   in   1      write request
//   read_enb    in   1      read request from the output port
//   lfd_state   in   1      data_in is a header byte; stored with it
//   data_in     in   WIDTH  byte to write
//   data_out    out  WIDTH  registered read data (1-cycle latency)
//   full        out  1      DEPTH entries held (combinational)
//   empty       out  1      no entries held (combinational)
// ---------------------------------------------------------------------------
module router_fifo_ch #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = 7;
  localparam int LEN_W = WIDTH - 2;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Storage: bit WIDTH is the header flag, bits [WIDTH-1:0] the byte.
  logic [WIDTH:0]       mem_reg [DEPTH];

  logic [PTR_W:0]       wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]       rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     pkt_cnt_reg, pkt_cnt_next;
  logic [WIDTH-1:0]     data_out_reg, data_out_next;

  logic [PTR_W-1:0]     wr_idx;
  logic [PTR_W-1:0]     rd_idx;
  logic [WIDTH:0]       rd_word;
  logic [CNT_W-1:0]     hdr_len;
  logic [DEPTH-1:0]     wr_sel;
  logic                 wr_accept;
  logic                 rd_accept;
  logic                 flush;
  logic                 timeout_flush;

  assign wr_idx = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx = rd_ptr_reg[PTR_W-1:0];

  // Status is derived straight from the pointers; the wrap bit separates the
  // full case from the empty case when the index bits match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);

  // A flush cycle swallows any same-cycle read or write request.
  assign flush     = soft_reset || timeout_flush;
  assign wr_accept = write_enb && !full && !flush;
  assign rd_accept = read_enb && !empty && !flush;

  assign rd_word  = mem_reg[rd_idx];
  assign data_out = data_out_reg;

  // Header payload length, widened (or trimmed) to the packet counter width.
  generate
    if (LEN_W >= CNT_W) begin : g_len_trunc
      assign hdr_len = rd_word[CNT_W+1:2];
    end else begin : g_len_ext
      assign hdr_len = {{(CNT_W-LEN_W){1'b0}}, rd_word[WIDTH-1:2]};
    end
  endgenerate

  // One-hot write select per storage entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_accept && (wr_idx == PTR_W'(gi));
    end
  endgenerate

  // Memory: fully cleared on reset so no stale header flag can be mistaken
  // for the start of a new packet after a hard reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem_reg[i] <= {lfd_state, data_in};
        end
      end
    end
  end

`ifdef ROUTER_FIFO_TIMEOUT_EN
  // Stall counter: counts consecutive cycles with data held and no read
  // request. Reaching 29 makes the following edge a flush, which also
  // returns the counter to zero.
  logic [4:0] stall_cnt_reg, stall_cnt_next;

  always_comb begin
    stall_cnt_next = '0;
    if (!flush && !empty && !read_enb) begin
      stall_cnt_next = stall_cnt_reg + 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign timeout_flush = (stall_cnt_reg == 5'd29);
`else
  assign timeout_flush = 1'b0;
`endif

  // Pointer, packet counter and output register next-state.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    pkt_cnt_next  = pkt_cnt_reg;
    data_out_next = data_out_reg;

    if (flush) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      pkt_cnt_next  = '0;
      data_out_next = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end

      if (rd_accept) begin
        rd_ptr_next   = rd_ptr_reg + PTR_ONE;
        data_out_next = rd_word[WIDTH-1:0];
        // A header reloads the counter with payload length plus the
        // trailing parity byte; every other byte counts down to zero.
        if (rd_word[WIDTH]) begin
          pkt_cnt_next = hdr_len + CNT_ONE;
        end else if (pkt_cnt_reg != '0) begin
          pkt_cnt_next = pkt_cnt_reg - CNT_ONE;
        end
      end else if (pkt_cnt_reg == '0) begin
        // Between packets the output bus is driven low.
        data_out_next = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pkt_cnt_reg  <= '0;
      data_out_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      data_out_reg <= data_out_next;
    end
  end

endmodule

// File: tb/tb_router_fifo_ch.sv
// tb_router_fifo_ch
// Self-checking bench for router_fifo_ch (DEPTH=16, WIDTH=8). A behavioural
// queue tracks the FIFO contents; each accepted read pushes its expected byte
// onto a scoreboard which the scenario tasks pop and compare one cycle later.
module tb_router_fifo_ch;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clock;
  logic             reset;
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  int total;
  int bad;

  logic [WIDTH:0]   mq[$];     // model FIFO contents {flag, byte}
  logic [WIDTH-1:0] exp_q[$];  // scoreboard of expected read bytes
  logic [WIDTH-1:0] exp;

  router_fifo_ch #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle of stimulus; the model decides acceptance from its own
  // occupancy as seen before the edge.
  task automatic step(input logic we, input logic re, input logic lfd, input logic [7:0] din);
    logic rd_ok;
    logic wr_ok;
    logic [WIDTH:0] w;
    write_enb = we;
    read_enb  = re;
    lfd_state = lfd;
    data_in   = din;
    rd_ok = re && (mq.size() != 0);
    wr_ok = we && (mq.size() != DEPTH);
    @(posedge clock);
    #1;
    if (rd_ok) begin
      w = mq.pop_front();
      exp_q.push_back(w[WIDTH-1:0]);
    end
    if (wr_ok) mq.push_back({lfd, din});
    write_enb = 1'b0;
    read_enb  = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; write_enb = 1'b1; data_in = 8'hEE; lfd_state = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    mq.delete(); exp_q.delete();
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    if (empty !== 1'b1 || data_out !== 8'h00) begin
      bad++; $display("FAIL reset_no_entry: empty=%b data_out=%h want empty=1 data_out=00", empty, data_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_packet();
    logic [7:0] pkt [5];
    pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5F;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, (i == 0), pkt[i]);
    total++;
    if (empty !== 1'b0) begin bad++; $display("FAIL pkt_not_empty: got %b want 0", empty); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL pkt_rd%0d: got %h want queued byte (none)", i, data_out);
      end else begin
        exp = exp_q.pop_front();
        if (data_out !== exp) begin bad++; $display("FAIL pkt_rd%0d: got %h want %h", i, data_out, exp); end
      end
      if (i == 3) begin
        // Parity still pending: the output must hold rather than drop to 0.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total++;
        if (data_out !== 8'hA3) begin bad++; $display("FAIL pkt_hold: got %h want a3", data_out); end
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL pkt_idle_zero: got %h want 00", data_out); end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL pkt_empty_end: got %b want 1", empty); end
    $display("test_single_packet done");
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL full_set: got %b want 1", full); end
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL full_17th: got %b want 1", full); end
    step(1'b1, 1'b1, 1'b0, 8'h77);
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL full_rw_drop: got %b want 0", full); end
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) step(1'b0, 1'b1, 1'b0, 8'h00);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL full_rd%0d: got %h want queued byte (none)", i, data_out);
      end else begin
        exp = exp_q.pop_front();
        if (data_out !== exp) begin bad++; $display("FAIL full_rd%0d: got %h want %h", i, data_out, exp); end
      end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL full_drained: got %b want 1", empty); end
    $display("test_full done");
  endtask

  task automatic test_wrap();
    int errs;
    errs = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + r * 16 + i));
      for (int i = 0; i < 12; i++) begin
        step(1'b0, 1'b1, 1'b0, 8'h00);
        total++;
        if (exp_q.size() == 0) begin
          bad++; errs++; $display("FAIL wrap_r%0d_rd%0d: got %h want queued byte (none)", r, i, data_out);
        end else begin
          exp = exp_q.pop_front();
          if (data_out !== exp) begin
            bad++; errs++; $display("FAIL wrap_r%0d_rd%0d: got %h want %h", r, i, data_out, exp);
          end
        end
      end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", empty); end
    $display("test_wrap done errors=%0d", errs);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b0, 8'hC0);
    step(1'b1, 1'b0, 1'b0, 8'hC1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'hD0 + 8'(i));
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL b2b_rd%0d: got %h want queued byte (none)", i, data_out);
      end else begin
        exp = exp_q.pop_front();
        if (data_out !== exp || empty !== 1'b0 || full !== 1'b0) begin
          bad++; $display("FAIL b2b_rd%0d: got %h e=%b f=%b want %h e=0 f=0", i, data_out, empty, full, exp);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
      if (data_out !== exp) begin bad++; $display("FAIL b2b_drain%0d: got %h want %h", i, data_out, exp); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b want 1", empty); end
    $display("test_back_to_back done");
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, 1'b1, 8'h15);  // header: length 5, dest 1
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
    if (data_out !== exp) begin bad++; $display("FAIL flush_pre_rd: got %h want %h", data_out, exp); end
    soft_reset = 1'b1; write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h99;
    @(posedge clock);
    #1;
    soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    mq.delete(); exp_q.delete();
    total++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      bad++; $display("FAIL flush_empty: empty=%b full=%b want empty=1 full=0", empty, full);
    end
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL flush_data_out: got %h want 00", data_out); end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      bad++; $display("FAIL flush_read_nothing: data_out=%h empty=%b want 00 1", data_out, empty);
    end
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
    if (data_out !== exp) begin bad++; $display("FAIL flush_after_rd: got %h want %h", data_out, exp); end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid_packet();
    step(1'b1, 1'b0, 1'b1, 8'h0D);
    step(1'b1, 1'b0, 1'b0, 8'hB1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    exp_q.delete();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
    total++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      bad++; $display("FAIL midrst_state: data_out=%h empty=%b want 00 1", data_out, empty);
    end
    step(1'b1, 1'b0, 1'b0, 8'h2A);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
    if (data_out !== exp) begin bad++; $display("FAIL midrst_rd: got %h want %h", data_out, exp); end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_no_carry: got %h want 00", data_out); end
    $display("test_reset_mid_packet done");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h80 + 8'(i));
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    total++;
`ifdef ROUTER_FIFO_TIMEOUT_EN
    if (empty !== 1'b1) begin bad++; $display("FAIL timeout_flush: got empty=%b want 1", empty); end
    mq.delete(); exp_q.delete();
`else
    if (empty !== 1'b0) begin bad++; $display("FAIL timeout_none: got empty=%b want 0", empty); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
      if (data_out !== exp) begin bad++; $display("FAIL timeout_rd%0d: got %h want %h", i, data_out, exp); end
    end
`endif
    $display("test_timeout done");
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    soft_reset = 1'b0;
    write_enb = 1'b0;
    read_enb = 1'b0;
    lfd_state = 1'b0;
    data_in = '0;
    test_reset();
    test_single_packet();
    test_full();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid_packet();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
